mvp_acc: RTL and testbench
==========================

// Module: mvp_acc
// PURPOSE
//  Downstream stage of the matrix-vector product array. Consumes one beat per cycle
//  of N signed partial dot-products, each A+2 bits, one beat per bit-plane pair of
//  weights/data. Accumulates the beats into N wide signed accumulators, with an
//  optional left shift per beat for MSB-first bit-serial precision. Presents the
//  finished vector through a valid/ready output with full backpressure.
// PARAMETERS
//  N     64            lanes; must equal the mvp array size
//  A     $clog2(N)     derived; input element width is A+2 (signed)
//  ACCW  32            accumulator/output element width (signed), ACCW >= A+2
//  CNTW  8             width of the plane counter
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   1          beat present on in_s
//  in_ready   out  1          stage can accept a beat
//  in_s       in   N*(A+2)    lane i = in_s[i*(A+2) +: A+2], two's complement
//  in_first   in   1          beat starts a new accumulation (load, no add)
//  in_last    in   1          beat ends the accumulation
//  in_shift   in   1          shift accumulator left 1 before adding this beat
//  out_valid  out  1          out_data holds a finished result
//  out_ready  in   1          consumer takes the result
//  out_data   out  N*ACCW     lane i = out_data[i*ACCW +: ACCW], two's complement
//  out_planes out  CNTW       beats folded into out_data, saturating at 2^CNTW-1
//  err        out  1          sticky protocol-error flag
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; out_valid=0, out_data=0, out_planes=0,
//    err=0, all accumulators 0. Reset mid-accumulation discards partial sums.
//  - Beat accepted when in_valid && in_ready. in_ready = !out_valid || out_ready.
//  - States: IDLE (no accumulation open), ACC (accumulation open), DONE (out_valid=1).
//    IDLE --accept,!last--> ACC;  IDLE/ACC --accept,last--> DONE;
//    ACC --accept,!last--> ACC;   DONE --out_ready, no accept--> IDLE;
//    DONE --out_ready & accept--> ACC or DONE, as for an accept from IDLE.
//  - Per-lane update on accept, s = sign-extend(in_s lane) to ACCW:
//    first-beat: acc = s;  otherwise acc = (in_shift ? acc<<1 : acc) + s,
//    modulo 2^ACCW (wrap, no saturation). The shift discards the MSB.
//  - A beat is a first-beat if in_first=1, or if it is accepted in IDLE or DONE.
//    Accepted in IDLE/DONE with in_first=0: load anyway and set err.
//    Accepted in ACC with in_first=1: restart (load), set err; partial sum is lost.
//  - Plane counter: a first-beat sets it to 1; each other beat adds 1; it holds at
//    2^CNTW-1 (no wrap).
//  - Latency: a last beat accepted at cycle t gives out_valid=1 at t+1, with
//    out_data/out_planes final. They hold stable until the cycle out_ready=1.
//  - Back-to-back: while DONE with out_ready=1, a new beat is accepted the same
//    cycle. The handoff drops no result and adds no bubble, so throughput is one
//    beat per cycle.
//  - Single-beat vector (in_first=in_last=1): out_data = sext(in_s), out_planes=1.
//  - out_data is the accumulator register itself, so no extra storage is needed.
//    It changes only on accept.
//  - in_shift on a first-beat is ignored.
//  - err clears only on reset.
// TESTING
//  1 Reset: hold rst_n=0 mid-ACC, release -> out_valid=0, out_data=0, out_planes=0,
//    err=0; next single beat gives the fresh value.
//  2 Single beat, all lanes in_s=+1, first=last=1 -> next cycle out_valid=1,
//    every lane=1, out_planes=1.
//  3 Bit-serial: 3 beats, lane values 3,-1,2 with shift=1 on beats 2-3 ->
//    ((3*2)-1)*2+2 = 12 in every lane, out_planes=3.
//  4 Backpressure: result pending, out_ready=0 for 5 cycles with in_valid=1 ->
//    in_ready=0, out_data stable. Then out_ready=1 -> new first beat accepted the
//    same cycle, and the next result follows with no bubble.
//  5 Wrap/extremes: lane in_s=-(2^(A+1)) summed 2^(ACCW-A-1)+1 times, no shift ->
//    two's-complement wrap matches the model. Also 2^CNTW+3 beats -> out_planes
//    saturates at 2^CNTW-1.
//  6 Protocol errors: first=0 beat in IDLE -> loads and err=1. first=1 beat in ACC
//    -> restarts and err stays 1 until reset.

Source files
------------

// File: rtl/mvp_acc_if.sv
// Handshake bundle between the mvp array and its accumulator stage.
// The producer/consumer side uses master; the accumulator uses slave.
interface mvp_acc_if #(
  parameter int N    = 64,
  parameter int ACCW = 32,
  parameter int CNTW = 8
);
  localparam int A  = $clog2(N);
  localparam int EW = A + 2;

  logic              in_valid;
  logic              in_ready;
  logic [N*EW-1:0]   in_s;
  logic              in_first;
  logic              in_last;
  logic              in_shift;
  logic              out_valid;
  logic              out_ready;
  logic [N*ACCW-1:0] out_data;
  logic [CNTW-1:0]   out_planes;
  logic              err;

  modport master (
    output in_valid, in_s, in_first, in_last, in_shift, out_ready,
    input  in_ready, out_valid, out_data, out_planes, err
  );

  modport slave (
    input  in_valid, in_s, in_first, in_last, in_shift, out_ready,
    output in_ready, out_valid, out_data, out_planes, err
  );
endinterface

// File: rtl/mvp_acc.sv
// Accumulates per-lane signed partial dot-products from the mvp array into
// wide accumulators, with optional MSB-first shift, behind a valid/ready output.
module mvp_acc #(
  parameter int N    = 64,
  parameter int ACCW = 32,
  parameter int CNTW = 8
) (
  input logic      clk,
  input logic      rst_n,
  mvp_acc_if.slave bus
);
  localparam int A  = $clog2(N);
  localparam int EW = A + 2;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   accept;
  logic                   first_beat;
  logic                   proto_err;
  logic signed [ACCW-1:0] acc     [N];
  logic signed [ACCW-1:0] acc_nxt [N];
  logic [CNTW-1:0]        planes;
  logic                   err_q;

  function automatic logic signed [ACCW-1:0] sext(input logic signed [EW-1:0] v);
    logic signed [ACCW-1:0] r;
    r = v;
    return r;
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (&c) ? c : c + CNTW'(1);
  endfunction

  assign bus.out_valid  = (state == DONE);
  assign bus.in_ready   = !bus.out_valid || bus.out_ready;
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.out_planes = planes;
  assign bus.err        = err_q;

  // Any beat that opens an accumulation loads; one arriving outside ACC
  // without in_first, or inside ACC with in_first, is a protocol error.
  always_comb begin
    state_nxt  = state;
    first_beat = 1'b0;
    proto_err  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          first_beat = 1'b1;
          proto_err  = !bus.in_first;
          state_nxt  = bus.in_last ? DONE : ACC;
        end else if (state == DONE && bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      ACC: begin
        if (accept) begin
          first_beat = bus.in_first;
          proto_err  = bus.in_first;
          state_nxt  = bus.in_last ? DONE : ACC;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic signed [ACCW-1:0] s;
    logic signed [ACCW-1:0] base;
    assign s          = sext(bus.in_s[i*EW +: EW]);
    assign base       = bus.in_shift ? (acc[i] <<< 1) : acc[i];
    assign acc_nxt[i] = first_beat ? s : base + s;
  end

  // The accumulators double as the output register.
  always_comb begin
    bus.out_data = '0;
    for (int i = 0; i < N; i++) begin
      bus.out_data[i*ACCW +: ACCW] = acc[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      planes <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        acc[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (proto_err) begin
        err_q <= 1'b1;
      end
      if (accept) begin
        planes <= first_beat ? CNTW'(1) : sat_inc(planes);
        for (int i = 0; i < N; i++) begin
          acc[i] <= acc_nxt[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_mvp_acc.sv
// Scoreboard bench for mvp_acc: directed beats push hand-computed results,
// a monitor pops and compares every delivered output vector.
module tb_mvp_acc;
  localparam int N    = 4;
  localparam int ACCW = 8;
  localparam int CNTW = 4;
  localparam int A    = $clog2(N);
  localparam int EW   = A + 2;

  typedef struct {
    logic [N*ACCW-1:0] data;
    logic [CNTW-1:0]   planes;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];

  mvp_acc_if #(.N(N), .ACCW(ACCW), .CNTW(CNTW)) bus ();

  mvp_acc #(.N(N), .ACCW(ACCW), .CNTW(CNTW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*EW-1:0] pin(input int v);
    logic [N*EW-1:0] r;
    for (int i = 0; i < N; i++) r[i*EW +: EW] = EW'(v);
    return r;
  endfunction

  function automatic logic [N*ACCW-1:0] pout(input int v);
    logic [N*ACCW-1:0] r;
    for (int i = 0; i < N; i++) r[i*ACCW +: ACCW] = ACCW'(v);
    return r;
  endfunction

  task automatic push(input logic [N*ACCW-1:0] d, input int p);
    exp_t e;
    e.data   = d;
    e.planes = CNTW'(p);
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic drive_beat(input logic [N*EW-1:0] s, input logic f, input logic l,
                            input logic sh);
    logic rdy;
    int   n;
    bus.in_s     = s;
    bus.in_first = f;
    bus.in_last  = l;
    bus.in_shift = sh;
    bus.in_valid = 1'b1;
    rdy = 1'b0;
    n   = 0;
    while (!rdy && n < 100) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drive_rep(input int v, input int cnt, input logic sh);
    for (int k = 0; k < cnt; k++) begin
      drive_beat(pin(v), k == 0, k == cnt - 1, (k != 0) && sh);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every delivered vector must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got %h with nothing expected", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 64'(bus.out_data), 64'(e.data));
          check("out_planes", 64'(bus.out_planes), 64'(e.planes));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_s     = '0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_shift = 1'b0;
    bus.out_ready = 1'b1;

    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of an open accumulation
    drive_beat(pin(3), 1'b1, 1'b0, 1'b0);
    drive_beat(pin(2), 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_out_data", 64'(bus.out_data), 64'd0);
    check("midrst_out_planes", 64'(bus.out_planes), 64'd0);
    check("midrst_err", 64'(bus.err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(pout(4), 1);
    drive_beat(pin(4), 1'b1, 1'b1, 1'b0);

    // Single beats: all +1, per-lane distinct, shift ignored on a first beat
    push(pout(1), 1);
    drive_beat(pin(1), 1'b1, 1'b1, 1'b0);
    push(32'hF807FE01, 1);
    drive_beat(16'h87E1, 1'b1, 1'b1, 1'b0);
    push(pout(3), 1);
    drive_beat(pin(3), 1'b1, 1'b1, 1'b1);

    // Bit-serial: ((3*2)-1)*2+2 = 12; without the middle shift (3-1)*2+2 = 6
    push(pout(12), 3);
    drive_beat(pin(3), 1'b1, 1'b0, 1'b0);
    drive_beat(pin(-1), 1'b0, 1'b0, 1'b1);
    drive_beat(pin(2), 1'b0, 1'b1, 1'b1);
    push(pout(6), 3);
    drive_beat(pin(3), 1'b1, 1'b0, 1'b0);
    drive_beat(pin(-1), 1'b0, 1'b0, 1'b0);
    drive_beat(pin(2), 1'b0, 1'b1, 1'b1);
    drain();
    check("err_clean", 64'(bus.err), 64'd0);

    // Backpressure with a pending result
    bus.out_ready = 1'b0;
    push(pout(2), 1);
    drive_beat(pin(2), 1'b1, 1'b1, 1'b0);
    bus.in_s     = pin(5);
    bus.in_first = 1'b1;
    bus.in_last  = 1'b1;
    bus.in_shift = 1'b0;
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_hold_data", 64'(bus.out_data), 64'(pout(2)));
      @(posedge clk);
      #1;
    end
    push(pout(5), 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("handoff_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    push(pout(6), 1);
    bus.in_s = pin(6);
    @(negedge clk);
    check("no_bubble_valid", 64'(bus.out_valid), 64'd1);
    check("no_bubble_data", 64'(bus.out_data), 64'(pout(5)));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drain();

    // Wrap: -8 * 33 = -264 == -8 mod 256; planes saturate at 15
    push(pout(-8), 15);
    drive_rep(-8, 33, 1'b0);
    push(pout(19), 15);
    drive_rep(1, 19, 1'b0);
    // Shift drops the MSB: 7,21,49,105,217->-39, -78+7 = -71
    push(pout(-71), 6);
    drive_rep(7, 6, 1'b1);
    drain();

    // Protocol errors
    push(pout(5), 1);
    drive_beat(pin(5), 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("err_idle_nofirst", 64'(bus.err), 64'd1);
    @(posedge clk);
    #1;
    push(pout(5), 2);
    drive_beat(pin(4), 1'b1, 1'b0, 1'b0);
    drive_beat(pin(3), 1'b1, 1'b0, 1'b0);
    drive_beat(pin(2), 1'b0, 1'b1, 1'b0);
    drain();
    check("err_sticky", 64'(bus.err), 64'd1);
    rst_n = 1'b0;
    #1;
    check("err_cleared_by_rst", 64'(bus.err), 64'd0);
    check("final_rst_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
